sprite_bg_restore: RTL and testbench



---
 rtl/sprite_pkg.sv | 28 ++
 rtl/sprite_raster_counter.sv | 50 +++++
 rtl/sprite_bg_restore.sv | 161 ++++++++++++++++
 tb/tb_sprite_bg_restore.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite draw/restore blocks.
// Screen geometry, colour field layout and map indices live here.
package sprite_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_t;

  localparam int SCREEN_W_DEF = 160;
  localparam int SCREEN_H_DEF = 120;
  localparam int COL_LSB_DEF  = 8;
  localparam int COL_W_DEF    = 9;

  localparam logic [1:0] MAP1  = 2'd0;
  localparam logic [1:0] MAP2  = 2'd1;
  localparam logic [1:0] START = 2'd2;

  typedef struct packed {
    logic       live;
    logic       vld;
    logic [7:0] px;
    logic [6:0] py;
  } slot_t;

endpackage

// File: rtl/sprite_raster_counter.sv
// Raster walker over a sprite rectangle: col inner, row outer.
// Emits absolute screen coords and a last-pixel flag.
module sprite_raster_counter #(
  parameter int SPR_W = 15,
  parameter int SPR_H = 15,
  parameter int CW    = $clog2(SPR_W + 1),
  parameter int RW    = $clog2(SPR_H + 1)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       en,
  input  logic [7:0] base_x,
  input  logic [6:0] base_y,
  output logic [8:0] px,
  output logic [7:0] py,
  output logic       last
);

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          col_end;
  logic          row_end;

  assign col_end = (col == CW'(SPR_W - 1));
  assign row_end = (row == RW'(SPR_H - 1));
  assign last    = col_end && row_end;

  // Widened so coordinates past the screen edge never wrap.
  assign px = {1'b0, base_x} + 9'(col);
  assign py = {1'b0, base_y} + 8'(row);

  always_ff @(posedge clk) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (clear) begin
      col <= '0;
      row <= '0;
    end else if (en) begin
      if (col_end) begin
        col <= '0;
        row <= row_end ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sprite_bg_restore.sv
// Background restore engine: re-plots the map pixels under a sprite
// rectangle, one pixel per cycle, with edge clipping and ROM latency.
module sprite_bg_restore
  import sprite_pkg::*;
#(
  parameter int SPR_W    = 15,
  parameter int SPR_H    = 15,
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF,
  parameter int ADDR_W   = 15,
  parameter int WORD_W   = 32,
  parameter int COL_LSB  = COL_LSB_DEF,
  parameter int COL_W    = COL_W_DEF,
  parameter int NUM_MAPS = 3,
  parameter int MEM_LAT  = 1
) (
  input  logic                       iClock,
  input  logic                       iReset,
  input  logic                       iStart,
  input  logic [7:0]                 iX,
  input  logic [6:0]                 iY,
  input  logic [1:0]                 iScreenSelect,
  input  logic [NUM_MAPS*WORD_W-1:0] iQ,
  output logic [ADDR_W-1:0]          oAddress,
  output logic [7:0]                 oX,
  output logic [6:0]                 oY,
  output logic [COL_W-1:0]           oColour,
  output logic                       oPlot,
  output logic                       oBusy,
  output logic                       oDone
);

  state_t     state;
  logic [7:0] base_x;
  logic [6:0] base_y;
  logic [1:0] base_sel;

  slot_t a_slot;
  slot_t pipe [MEM_LAT];
  slot_t tail;

  logic [8:0]       px;
  logic [7:0]       py;
  logic             last;
  logic             in_scr;
  logic             any_live;
  logic             cnt_clear;
  logic             cnt_en;
  logic [COL_W-1:0] col_sel;
  logic             unused_q;

  assign cnt_clear = (state == IDLE) && iStart;
  assign cnt_en    = (state == ISSUE);

  sprite_raster_counter #(
    .SPR_W(SPR_W),
    .SPR_H(SPR_H)
  ) u_cnt (
    .clk   (iClock),
    .rst   (iReset),
    .clear (cnt_clear),
    .en    (cnt_en),
    .base_x(base_x),
    .base_y(base_y),
    .px    (px),
    .py    (py),
    .last  (last)
  );

  assign in_scr = (32'(px) < 32'(SCREEN_W))
               && (32'(py) < 32'(SCREEN_H));

  assign tail     = pipe[MEM_LAT-1];
  assign unused_q = ^iQ;

  // Unknown map indices restore to black rather than a stale map.
  always_comb begin
    col_sel = '0;
    for (int k = 0; k < NUM_MAPS; k++) begin
      if (32'(base_sel) == k) begin
        col_sel = iQ[k*WORD_W+COL_LSB +: COL_W];
      end
    end
  end

  always_comb begin
    any_live = a_slot.live;
    for (int i = 0; i < MEM_LAT; i++) begin
      any_live = any_live | pipe[i].live;
    end
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      state    <= IDLE;
      base_x   <= '0;
      base_y   <= '0;
      base_sel <= '0;
      a_slot   <= '0;
      for (int i = 0; i < MEM_LAT; i++) begin
        pipe[i] <= '0;
      end
      oAddress <= '0;
      oX       <= '0;
      oY       <= '0;
      oColour  <= '0;
      oPlot    <= 1'b0;
      oBusy    <= 1'b0;
      oDone    <= 1'b0;
    end else begin
      a_slot  <= '0;
      pipe[0] <= a_slot;
      for (int i = 1; i < MEM_LAT; i++) begin
        pipe[i] <= pipe[i-1];
      end
      oPlot <= tail.live && tail.vld;
      if (tail.live && tail.vld) begin
        oX      <= tail.px;
        oY      <= tail.py;
        oColour <= col_sel;
      end
      oDone <= 1'b0;
      unique case (state)
        IDLE: begin
          if (iStart) begin
            base_x   <= iX;
            base_y   <= iY;
            base_sel <= iScreenSelect;
            oBusy    <= 1'b1;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          // Clipped slots still occupy a pipeline slot to keep timing fixed.
          a_slot.live <= 1'b1;
          a_slot.vld  <= in_scr;
          a_slot.px   <= px[7:0];
          a_slot.py   <= py[6:0];
          if (in_scr) begin
            oAddress <= ADDR_W'(32'(py) * 32'(SCREEN_W) + 32'(px));
          end
          if (last) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (!any_live) begin
            oDone <= 1'b1;
            oBusy <= 1'b0;
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_bg_restore.sv
// Scoreboard bench: two engines (ROM latency 1 and 3) share stimulus;
// a raster-walk model predicts every plot and the done cycle.
module tb_sprite_bg_restore;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start;
  logic [7:0]  x_in;
  logic [6:0]  y_in;
  logic [1:0]  sel_in;
  logic [95:0] q    [2];
  logic [14:0] addr [2];
  logic [7:0]  ox   [2];
  logic [6:0]  oy   [2];
  logic [8:0]  ocol [2];
  logic        plot [2];
  logic        busy [2];
  logic        done [2];

  sprite_bg_restore #(.MEM_LAT(1)) u_l1 (
    .iClock(clk), .iReset(rst), .iStart(start),
    .iX(x_in), .iY(y_in), .iScreenSelect(sel_in), .iQ(q[0]),
    .oAddress(addr[0]), .oX(ox[0]), .oY(oy[0]), .oColour(ocol[0]),
    .oPlot(plot[0]), .oBusy(busy[0]), .oDone(done[0])
  );

  sprite_bg_restore #(.MEM_LAT(3)) u_l3 (
    .iClock(clk), .iReset(rst), .iStart(start),
    .iX(x_in), .iY(y_in), .iScreenSelect(sel_in), .iQ(q[1]),
    .oAddress(addr[1]), .oX(ox[1]), .oY(oy[1]), .oColour(ocol[1]),
    .oPlot(plot[1]), .oBusy(busy[1]), .oDone(done[1])
  );

  // ROM contents: colour field of map k at address a is a*(k+1)+77k.
  function automatic logic [31:0] rom_word(int k, logic [14:0] a);
    int v;
    v = int'(a) * (k + 1) + k * 77;
    return (32'(v) << 8) | 32'h5A;
  endfunction

  logic [14:0] dl1;
  logic [14:0] dl3 [3];
  always @(posedge clk) begin
    dl1    <= addr[0];
    dl3[0] <= addr[1];
    dl3[1] <= dl3[0];
    dl3[2] <= dl3[1];
  end
  assign q[0] = {rom_word(2, dl1), rom_word(1, dl1), rom_word(0, dl1)};
  assign q[1] = {rom_word(2, dl3[2]), rom_word(1, dl3[2]),
                 rom_word(0, dl3[2])};

  typedef struct {
    int t;
    int x;
    int y;
    int c;
  } plot_t;

  plot_t exp_q   [2][$];
  int    done_q  [2][$];
  int    done_cnt[2];
  int    cyc   = 0;
  int    total = 0;
  int    bad   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, int act, int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  plot_t e;
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (plot[d]) begin
        if (exp_q[d].size() == 0) begin
          check($sformatf("extra_plot_dut%0d", d), 1, 0);
        end else begin
          e = exp_q[d].pop_front();
          total++;
          if (cyc != e.t || ox[d] != e.x || oy[d] != e.y || ocol[d] != e.c) begin
            bad++;
            $display("FAIL plot_dut%0d: got t=%0d x=%0d y=%0d c=%0d expected t=%0d x=%0d y=%0d c=%0d",
                     d, cyc, ox[d], oy[d], ocol[d], e.t, e.x, e.y, e.c);
          end
        end
      end
      if (done[d]) begin
        done_cnt[d]++;
        if (done_q[d].size() == 0) check($sformatf("extra_done_dut%0d", d), 1, 0);
        else check($sformatf("done_cycle_dut%0d", d), cyc, done_q[d].pop_front());
      end
    end
  end

  // Raster walk of the rectangle; plots past 'cut' are lost to a reset.
  task automatic model(int x, int y, int s, int acc, int cut);
    for (int d = 0; d < 2; d++) begin
      int lat;
      lat = (d == 0) ? 1 : 3;
      for (int k = 0; k < 225; k++) begin
        int px, py, a;
        plot_t p;
        px = x + k % 15;
        py = y + k / 15;
        p.t = acc + 2 + lat + k;
        if (px < 160 && py < 120 && !(cut > 0 && p.t >= cut)) begin
          a = (py * 160 + px) % 32768;
          p.x = px;
          p.y = py;
          p.c = (s < 3) ? (a * (s + 1) + s * 77) % 512 : 0;
          exp_q[d].push_back(p);
        end
      end
      if (cut == 0) done_q[d].push_back(acc + 227 + lat);
    end
  endtask

  task automatic run_job(int x, int y, int s, bit noise, int rst_px);
    int acc, tgt0, tgt1;
    bit ok;
    @(negedge clk);
    x_in   = 8'(x);
    y_in   = 7'(y);
    sel_in = 2'(s);
    start  = 1'b1;
    acc    = cyc + 1;
    tgt0   = done_cnt[0] + 1;
    tgt1   = done_cnt[1] + 1;
    model(x, y, s, acc, (rst_px >= 0) ? acc + 1 + rst_px : 0);
    @(negedge clk);
    start  = 1'b0;
    x_in   = 8'($urandom);
    y_in   = 7'($urandom);
    sel_in = 2'($urandom);
    check("busy_l1", int'(busy[0]), 1);
    check("busy_l3", int'(busy[1]), 1);
    if (rst_px >= 0) begin
      while (cyc < acc + rst_px) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int d = 0; d < 2; d++) begin
        check($sformatf("rst_plot_dut%0d", d), int'(plot[d]), 0);
        check($sformatf("rst_busy_dut%0d", d), int'(busy[d]), 0);
        check($sformatf("rst_done_dut%0d", d), int'(done[d]), 0);
      end
      repeat (4) @(negedge clk);
    end else begin
      ok = 1'b0;
      for (int i = 0; i < 600; i++) begin
        if (done_cnt[0] >= tgt0 && done_cnt[1] >= tgt1) begin
          ok = 1'b1;
          break;
        end
        start = (noise && cyc < acc + 200) ? 1'($urandom_range(0, 1)) : 1'b0;
        @(negedge clk);
      end
      start = 1'b0;
      if (!ok) check("done_timeout", 0, 1);
      repeat (2) @(negedge clk);
    end
  endtask

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    x_in   = '0;
    y_in   = '0;
    sel_in = '0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("reset_addr%0d", d), int'(addr[d]), 0);
      check($sformatf("reset_x%0d", d), int'(ox[d]), 0);
      check($sformatf("reset_y%0d", d), int'(oy[d]), 0);
      check($sformatf("reset_col%0d", d), int'(ocol[d]), 0);
      check($sformatf("reset_plot%0d", d), int'(plot[d]), 0);
      check($sformatf("reset_busy%0d", d), int'(busy[d]), 0);
      check($sformatf("reset_done%0d", d), int'(done[d]), 0);
    end
    rst = 1'b0;
    @(negedge clk);

    run_job(10, 20, 0, 1'b0, -1);
    run_job(150, 0, 0, 1'b0, -1);
    run_job(0, 110, 0, 1'b0, -1);
    run_job(200, 0, 0, 1'b0, -1);
    run_job(30, 40, 2, 1'b0, -1);
    run_job(30, 40, 1, 1'b0, -1);
    run_job(50, 60, 3, 1'b0, -1);
    run_job(12, 34, 1, 1'b1, -1);
    run_job(20, 30, 0, 1'b0, 100);
    run_job(5, 5, 2, 1'b0, -1);
    for (int j = 0; j < 4; j++) begin
      run_job(int'($urandom_range(0, 255)), int'($urandom_range(0, 127)),
              int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), -1);
    end

    repeat (10) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("leftover_plots%0d", d), exp_q[d].size(), 0);
      check($sformatf("leftover_done%0d", d), done_q[d].size(), 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
